// File: rtl/io_bus_arbiter.sv
// Two-master arbiter for the CPU I/O bus. It serves ports A and B round-robin,
// keeps one access in flight, holds each strobe for WAIT+1 cycles and acks completion.
module io_bus_arbiter #(
  parameter int WAIT = 1,
  parameter int AW   = 8,
  parameter int DW   = 16
) (
  input  logic          mclk,
  input  logic          mrst,
  input  logic          a_req,
  input  logic          a_wr,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_wr,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  output logic [AW-1:0] ioaddr,
  output logic [DW-1:0] dout,
  input  logic [DW-1:0] din,
  output logic          iord,
  output logic          iowr
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [2:0] WAIT_C = 3'(WAIT);

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          gnt_q, gnt_d;
  logic          last_q, last_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] ioaddr_q, ioaddr_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          iord_q, iord_d;
  logic          iowr_q, iowr_d;
  logic          a_ack_q, a_ack_d;
  logic          b_ack_q, b_ack_d;
  logic [DW-1:0] a_rdata_q, a_rdata_d;
  logic [DW-1:0] b_rdata_q, b_rdata_d;

  logic req_a_ok, req_b_ok, pick_b, sel_wr;

  always_comb begin
    // In DONE the port just served still shows its old request; ignore it.
    req_a_ok = a_req && !(state_q == DONE && gnt_q == 1'b0);
    req_b_ok = b_req && !(state_q == DONE && gnt_q == 1'b1);
    pick_b   = req_b_ok && (!req_a_ok || last_q == 1'b0);
    sel_wr   = pick_b ? b_wr : a_wr;

    state_d   = state_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    wr_d      = wr_q;
    ioaddr_d  = ioaddr_q;
    dout_d    = dout_q;
    iord_d    = 1'b0;
    iowr_d    = 1'b0;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;

    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) last_d = gnt_q;
        if (req_a_ok || req_b_ok) begin
          gnt_d    = pick_b;
          wr_d     = sel_wr;
          ioaddr_d = pick_b ? b_addr : a_addr;
          dout_d   = pick_b ? b_wdata : a_wdata;
          cnt_d    = WAIT_C;
          iord_d   = !sel_wr;
          iowr_d   = sel_wr;
          state_d  = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (cnt_q == 3'd0) begin
          if (!wr_q && !gnt_q) a_rdata_d = din;
          if (!wr_q &&  gnt_q) b_rdata_d = din;
          a_ack_d = !gnt_q;
          b_ack_d = gnt_q;
          state_d = DONE;
        end else begin
          cnt_d  = cnt_q - 3'd1;
          iord_d = !wr_q;
          iowr_d = wr_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge mclk or negedge mrst) begin
    if (!mrst) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      wr_q      <= 1'b0;
      ioaddr_q  <= '0;
      dout_q    <= '0;
      iord_q    <= 1'b0;
      iowr_q    <= 1'b0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      wr_q      <= wr_d;
      ioaddr_q  <= ioaddr_d;
      dout_q    <= dout_d;
      iord_q    <= iord_d;
      iowr_q    <= iowr_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign ioaddr  = ioaddr_q;
  assign dout    = dout_q;
  assign iord    = iord_q;
  assign iowr    = iowr_q;
  assign a_ack   = a_ack_q;
  assign b_ack   = b_ack_q;
  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;

endmodule
